doodle_motion_ctrl: RTL

- Per-frame motion controller for the doodle sprite.
- Runs the jump physics state machine (idle, rise, fall, dead) and handles horizontal input with wrap-around.
- Drives the sprite origin (x0, y0) and the 5-bit sprite control word of the doodle sprite generator.
- Sits between the button/collision logic and the sprite generator; also emits scroll requests to the platform scroller.

---
 rtl/doodle_motion_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/doodle_motion_ctrl.sv
// doodle_motion_ctrl: per-frame jump physics and horizontal movement for the
// doodle sprite. Drives the sprite origin/control word and scroll requests.
//
// Ports:
//   clk, reset    - system clock, synchronous active-high reset
//   frame_tick    - one-cycle pulse per video frame; all updates happen on it
//   start         - start/restart request (IDLE -> RISE, DEAD -> IDLE)
//   btn_left/right- horizontal move levels
//   land          - platform contact from the collision checker (FALL only)
//   x0, y0        - sprite origin
//   ctrl          - [4:3] colour, [2] auto, [1:0] sprite id ([0] = facing left)
//   falling       - high while in FALL
//   scroll_valid  - one-cycle pulse qualifying scroll_amt
//   scroll_amt    - pixels the world scrolls down this frame
//   game_over     - high in DEAD
module doodle_motion_ctrl #(
  parameter int X_START     = 304,
  parameter int X_MAX       = 608,
  parameter int Y_FLOOR     = 416,
  parameter int SCROLL_LINE = 160,
  parameter int JUMP_V      = 12,
  parameter int V_MAX       = 15,
  parameter int GRAV_DIV    = 2,
  parameter int X_STEP      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        land,
  output logic [10:0] x0,
  output logic [10:0] y0,
  output logic [4:0]  ctrl,
  output logic        falling,
  output logic        scroll_valid,
  output logic [7:0]  scroll_amt,
  output logic        game_over
);

  localparam int GW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;

  localparam logic signed [11:0] P_XSTEP  = 12'(X_STEP);
  localparam logic signed [11:0] P_XMAX   = 12'(X_MAX);
  localparam logic signed [11:0] P_XSPAN  = 12'(X_MAX + 1);
  localparam logic signed [11:0] P_XWRAPL = 12'(X_MAX + 1 - X_STEP);
  localparam logic signed [11:0] P_SLINE  = 12'(SCROLL_LINE);
  localparam logic signed [11:0] P_FLOOR  = 12'(Y_FLOOR);
  localparam logic [7:0]         P_JUMPV  = 8'(JUMP_V);
  localparam logic [7:0]         P_VMAX   = 8'(V_MAX);
  localparam logic [GW-1:0]      P_GLAST  = GW'(GRAV_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RISE, S_FALL, S_DEAD} state_t;

  state_t         state_q;
  logic [10:0]    x_q, y_q;
  logic [7:0]     vel_q;
  logic [GW-1:0]  g_q;
  logic [4:0]     ctrl_q;
  logic           falling_q, scroll_valid_q, game_over_q;
  logic [7:0]     scroll_amt_q;

  logic signed [11:0] x_s, y_s, vel_s;
  logic signed [11:0] rise_n, fall_n, x_left, x_right_raw, x_right, x_d;
  logic [7:0]         scroll_d;
  logic               rise_scroll, fall_floor, g_wrap, left_only, right_only;

  always_comb begin
    x_s         = signed'({1'b0, x_q});
    y_s         = signed'({1'b0, y_q});
    vel_s       = signed'({4'b0000, vel_q});
    rise_n      = y_s - vel_s;
    rise_scroll = rise_n < P_SLINE;
    scroll_d    = 8'(P_SLINE - rise_n);
    fall_n      = y_s + vel_s;
    fall_floor  = fall_n >= P_FLOOR;
    g_wrap      = (g_q == P_GLAST);
    left_only   = btn_left & ~btn_right;
    right_only  = btn_right & ~btn_left;
    // Both wrap directions are folded into one add/subtract each so x0 stays in 0..X_MAX.
    x_left      = (x_s < P_XSTEP) ? x_s + P_XWRAPL : x_s - P_XSTEP;
    x_right_raw = x_s + P_XSTEP;
    x_right     = (x_right_raw > P_XMAX) ? x_right_raw - P_XSPAN : x_right_raw;
    x_d         = x_s;
    if (left_only)       x_d = x_left;
    else if (right_only) x_d = x_right;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      x_q            <= 11'(X_START);
      y_q            <= 11'(Y_FLOOR);
      vel_q          <= '0;
      g_q            <= '0;
      ctrl_q         <= '0;
      falling_q      <= 1'b0;
      scroll_valid_q <= 1'b0;
      scroll_amt_q   <= '0;
      game_over_q    <= 1'b0;
    end else begin
      scroll_valid_q <= 1'b0;
      if (frame_tick) begin
        // Horizontal movement and facing apply on every airborne tick.
        if (state_q == S_RISE || state_q == S_FALL) begin
          x_q <= 11'(x_d);
          if (left_only)       ctrl_q[0] <= 1'b1;
          else if (right_only) ctrl_q[0] <= 1'b0;
        end
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              state_q <= S_RISE;
              vel_q   <= P_JUMPV;
              g_q     <= '0;
            end
          end
          S_RISE: begin
            if (rise_scroll) begin
              y_q            <= 11'(P_SLINE);
              scroll_amt_q   <= scroll_d;
              scroll_valid_q <= 1'b1;
            end else begin
              y_q <= 11'(rise_n);
            end
            if (g_wrap) begin
              g_q   <= '0;
              vel_q <= vel_q - 8'd1;
              if (vel_q == 8'd1) begin
                state_q   <= S_FALL;
                falling_q <= 1'b1;
              end
            end else begin
              g_q <= g_q + 1'b1;
            end
          end
          S_FALL: begin
            if (land) begin
              state_q   <= S_RISE;
              falling_q <= 1'b0;
              vel_q     <= P_JUMPV;
              g_q       <= '0;
            end else if (fall_floor) begin
              state_q     <= S_DEAD;
              falling_q   <= 1'b0;
              y_q         <= 11'(P_FLOOR);
              game_over_q <= 1'b1;
              ctrl_q[4:3] <= 2'b11;
            end else begin
              y_q <= 11'(fall_n);
              if (g_wrap) begin
                g_q <= '0;
                if (vel_q < P_VMAX) vel_q <= vel_q + 8'd1;
              end else begin
                g_q <= g_q + 1'b1;
              end
            end
          end
          S_DEAD: begin
            if (start) begin
              state_q     <= S_IDLE;
              x_q         <= 11'(X_START);
              y_q         <= 11'(Y_FLOOR);
              vel_q       <= '0;
              g_q         <= '0;
              ctrl_q      <= '0;
              game_over_q <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign x0           = x_q;
  assign y0           = y_q;
  assign ctrl         = ctrl_q;
  assign falling      = falling_q;
  assign scroll_valid = scroll_valid_q;
  assign scroll_amt   = scroll_amt_q;
  assign game_over    = game_over_q;

endmodule
